// File: rtl/serial_comparator_pkg.sv
// ---------------------------------------------------------------------------
// serial_comparator_pkg
//
// Shared definitions for the serial magnitude comparator:
//   state_t        - sequencer state encoding (IDLE, RUN)
//   flags_t        - registered result flags (lt, gt, eq)
//   nch_of()       - number of chunks a WIDTH-bit operand splits into
//   cnt_width_of() - chunk counter width, never narrower than one bit
// ---------------------------------------------------------------------------
package serial_comparator_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   typedef struct packed {
      logic lt;
      logic gt;
      logic eq;
   } flags_t;

   // Guarded so an illegal CHUNK of zero reaches the legality check in the
   // top level instead of failing on a division first.
   function automatic int nch_of(input int width, input int chunk);
      return (chunk > 0) ? (width / chunk) : 1;
   endfunction

   // A single-chunk compare still needs a one-bit counter to exist.
   function automatic int cnt_width_of(input int nch);
      return (nch > 1) ? $clog2(nch) : 1;
   endfunction

endpackage

// File: rtl/serial_comparator_chunk.sv
// ---------------------------------------------------------------------------
// comparator_chunk
//
// Purely combinational unsigned magnitude compare of two W-bit slices.
// Exactly one of lt/gt/eq is high for any input pair.
//
// Ports:
//   a, b   in  W  slices to compare (unsigned)
//   lt     out 1  a < b
//   gt     out 1  a > b
//   eq     out 1  a == b
// ---------------------------------------------------------------------------
module comparator_chunk #(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         lt,
   output logic         gt,
   output logic         eq
);

   assign lt = (a < b);
   assign gt = (a > b);
   assign eq = (a == b);

endmodule

// File: rtl/serial_comparator.sv
// ---------------------------------------------------------------------------
// serial_comparator
//
// Multi-cycle magnitude comparator. Two WIDTH-bit operands are compared
// MSB-first, CHUNK bits per clock, with optional two's-complement
// interpretation. The compare stops at the first differing chunk, so
// latency ranges from 1 to WIDTH/CHUNK clocks.
//
// Ports:
//   clk          in  1      rising-edge clock
//   rst_n        in  1      asynchronous active-low reset
//   start        in  1      compare request, sampled only while idle
//   signed_mode  in  1      1 = operands are two's complement (with start)
//   a            in  WIDTH  operand A (sampled with start)
//   b            in  WIDTH  operand B (sampled with start)
//   busy         out 1      compare in progress
//   done         out 1      one-cycle pulse, flags valid in this cycle
//   a_lt_b       out 1      registered result: A < B
//   a_gt_b       out 1      registered result: A > B
//   a_eq_b       out 1      registered result: A == B
// ---------------------------------------------------------------------------
module serial_comparator
   import serial_comparator_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             a_lt_b,
   output logic             a_gt_b,
   output logic             a_eq_b
);

   localparam int            NCH  = nch_of(WIDTH, CHUNK);
   localparam int            CW   = cnt_width_of(NCH);
   localparam logic [CW-1:0] LAST = CW'(NCH - 1);

   generate
      if ((CHUNK < 1) || (WIDTH < 2) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
         $error("serial_comparator: illegal WIDTH=%0d / CHUNK=%0d", WIDTH, CHUNK);
      end
   endgenerate

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q,   cnt_d;
   logic [WIDTH-1:0]   sh_a_q,  sh_a_d;
   logic [WIDTH-1:0]   sh_b_q,  sh_b_d;
   logic               sgn_q,   sgn_d;
   logic               done_q,  done_d;
   flags_t             flags_q, flags_d;

   // ------------------------------------------------------------------------
   // Chunk compare
   // ------------------------------------------------------------------------
   logic [CHUNK-1:0] chunk_a, chunk_b;
   logic             c_lt, c_gt, c_eq;

   // Flipping the sign bit of both leading chunks maps two's complement onto
   // offset binary, so the unsigned compare orders negatives below positives.
   // Later chunks carry magnitude only and are compared untouched.
   always_comb begin
      chunk_a = sh_a_q[WIDTH-1 -: CHUNK];
      chunk_b = sh_b_q[WIDTH-1 -: CHUNK];
      if (sgn_q && (cnt_q == '0)) begin
         chunk_a[CHUNK-1] = ~chunk_a[CHUNK-1];
         chunk_b[CHUNK-1] = ~chunk_b[CHUNK-1];
      end
   end

   comparator_chunk #(
      .W (CHUNK)
   ) u_chunk (
      .a  (chunk_a),
      .b  (chunk_b),
      .lt (c_lt),
      .gt (c_gt),
      .eq (c_eq)
   );

   // ------------------------------------------------------------------------
   // Next-state / datapath logic
   // ------------------------------------------------------------------------
   // NOTE: every signal gets its hold value before the case statement; a path
   // that leaves one unassigned would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sh_a_d  = sh_a_q;
      sh_b_d  = sh_b_q;
      sgn_d   = sgn_q;
      done_d  = 1'b0;
      flags_d = flags_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               sh_a_d  = a;
               sh_b_d  = b;
               sgn_d   = signed_mode;
               cnt_d   = '0;
               state_d = RUN;
            end
         end

         RUN: begin
            if (!c_eq) begin
               // First differing chunk decides the whole compare.
               flags_d = '{lt: c_lt, gt: c_gt, eq: 1'b0};
               done_d  = 1'b1;
               state_d = IDLE;
            end else if (cnt_q == LAST) begin
               flags_d = '{lt: 1'b0, gt: 1'b0, eq: 1'b1};
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               sh_a_d = sh_a_q << CHUNK;
               sh_b_d = sh_b_q << CHUNK;
               cnt_d  = cnt_q + CW'(1);
            end
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   // NOTE: non-blocking assignments make every register sample the values
   // from before the edge, independent of statement order.
   // The operand shifters are reset too: they are few flops, and a known
   // value keeps the datapath free of X after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sh_a_q  <= '0;
         sh_b_q  <= '0;
         sgn_q   <= 1'b0;
         done_q  <= 1'b0;
         flags_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sh_a_q  <= sh_a_d;
         sh_b_q  <= sh_b_d;
         sgn_q   <= sgn_d;
         done_q  <= done_d;
         flags_q <= flags_d;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign busy   = (state_q == RUN);
   assign done   = done_q;
   assign a_lt_b = flags_q.lt;
   assign a_gt_b = flags_q.gt;
   assign a_eq_b = flags_q.eq;

endmodule

// File: tb/tb_serial_comparator.sv
// ---------------------------------------------------------------------------
// tb_serial_comparator
//
// Directed bench for serial_comparator (WIDTH=16, CHUNK=4). A behavioural
// model predicts busy/done/flags from whole-operand arithmetic; a compare
// process checks the DUT against it on every falling edge. Each directed
// compare also checks hand-computed latency and flags.
// ---------------------------------------------------------------------------
module tb_serial_comparator;

   localparam int W   = 16;
   localparam int C   = 4;
   localparam int NCH = W / C;

   localparam logic [2:0] LT = 3'b100;
   localparam logic [2:0] GT = 3'b010;
   localparam logic [2:0] EQ = 3'b001;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         signed_mode = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy, done, a_lt_b, a_gt_b, a_eq_b;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   serial_comparator #(
      .WIDTH (W),
      .CHUNK (C)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .signed_mode (signed_mode),
      .a           (a),
      .b           (b),
      .busy        (busy),
      .done        (done),
      .a_lt_b      (a_lt_b),
      .a_gt_b      (a_gt_b),
      .a_eq_b      (a_eq_b)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------------
   // Behavioural model
   // ------------------------------------------------------------------------
   // Latency is the 1-based index of the first differing chunk from the top,
   // or NCH when the operands are equal.
   function automatic int first_diff(input logic [W-1:0] x, input logic [W-1:0] y);
      for (int i = 0; i < NCH; i++) begin
         if (((x >> (W - C * (i + 1))) & ((1 << C) - 1)) !=
             ((y >> (W - C * (i + 1))) & ((1 << C) - 1)))
            return i + 1;
      end
      return NCH;
   endfunction

   function automatic logic [2:0] expect_flags(input logic [W-1:0] x, input logic [W-1:0] y,
                                               input logic sm);
      int vx, vy;
      vx = sm ? int'($signed(x)) : int'(x);
      vy = sm ? int'($signed(y)) : int'(y);
      if (vx < vy) return LT;
      if (vx > vy) return GT;
      return EQ;
   endfunction

   int         m_left = 0;
   bit         m_busy = 1'b0;
   bit         m_done = 1'b0;
   logic [2:0] m_pend = '0;
   logic [2:0] m_res  = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_left <= 0;
         m_busy <= 1'b0;
         m_done <= 1'b0;
         m_pend <= '0;
         m_res  <= '0;
      end else begin
         m_done <= 1'b0;
         if (m_left == 0) begin
            if (start) begin
               m_left <= first_diff(a, b);
               m_busy <= 1'b1;
               m_pend <= expect_flags(a, b, signed_mode);
            end
         end else if (m_left == 1) begin
            m_left <= 0;
            m_busy <= 1'b0;
            m_done <= 1'b1;
            m_res  <= m_pend;
         end else begin
            m_left <= m_left - 1;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("model_busy",  busy, m_busy);
         check("model_done",  done, m_done);
         check("model_flags", {a_lt_b, a_gt_b, a_eq_b}, m_res);
      end
   end

   // ------------------------------------------------------------------------
   // Directed compare: called at a falling edge, returns at the falling edge
   // of the done cycle. With poke set, a second start with other operands is
   // driven during the first busy cycles and must be ignored.
   // ------------------------------------------------------------------------
   task automatic do_cmp(input logic [W-1:0] op_a, input logic [W-1:0] op_b, input logic sm,
                         input logic [2:0] exp_flags, input int exp_lat, input bit poke,
                         input string nm);
      int edges;
      a = op_a;
      b = op_b;
      signed_mode = sm;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      check({nm, "_busy"}, busy, 1'b1);
      edges = 0;
      do begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         if (poke && edges < 2) begin
            start = 1'b1;
            a = 16'hF000;
            b = 16'h0001;
            signed_mode = 1'b1;
         end else begin
            start = 1'b0;
         end
      end while (!done && edges < 20);
      start = 1'b0;
      check({nm, "_latency"}, edges, exp_lat);
      check({nm, "_flags"}, {a_lt_b, a_gt_b, a_eq_b}, exp_flags);
      check({nm, "_idle"}, busy, 1'b0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("reset_outputs", {busy, done, a_lt_b, a_gt_b, a_eq_b}, 5'b0);
      rst_n = 1'b1;
      chk_en = 1'b1;

      do_cmp(16'h1234, 16'h1234, 1'b0, EQ, 4, 1'b0, "eq_1234");
      @(negedge clk);
      do_cmp(16'hF000, 16'h8000, 1'b0, GT, 1, 1'b0, "u_f000_8000");
      @(negedge clk);
      do_cmp(16'hFFFF, 16'h0001, 1'b1, LT, 1, 1'b0, "s_ffff_0001");
      @(negedge clk);
      do_cmp(16'hFFFF, 16'h0001, 1'b0, GT, 1, 1'b0, "u_ffff_0001");
      @(negedge clk);
      do_cmp(16'h1235, 16'h1234, 1'b0, GT, 4, 1'b0, "u_1235_1234");
      @(negedge clk);
      do_cmp(16'h8000, 16'h8001, 1'b1, LT, 4, 1'b0, "s_8000_8001");
      @(negedge clk);
      do_cmp(16'h8000, 16'h0000, 1'b1, LT, 1, 1'b0, "s_8000_0000");
      @(negedge clk);
      // Start pulsed mid-compare with other operands must be ignored.
      do_cmp(16'h0010, 16'h0020, 1'b0, LT, 3, 1'b1, "poke_ignored");
      // Back-to-back: each new start is raised in the previous done cycle.
      do_cmp(16'h7FFF, 16'h8000, 1'b1, GT, 1, 1'b0, "b2b_signed");
      do_cmp(16'h7FFF, 16'h8000, 1'b0, LT, 1, 1'b0, "b2b_unsigned");

      // Asynchronous reset in the middle of a four-chunk compare.
      @(negedge clk);
      a = 16'h1234;
      b = 16'h1234;
      signed_mode = 1'b0;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1 check("async_reset", {busy, done, a_lt_b, a_gt_b, a_eq_b}, 5'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("no_done_after_reset", done, 1'b0);
      end
      do_cmp(16'h0003, 16'h0003, 1'b0, EQ, 4, 1'b0, "eq_3_after_reset");

      repeat (2) @(negedge clk);
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/serial_comparator.md
# serial_comparator

Parametrised multi-cycle magnitude comparator: compares two WIDTH-bit operands MSB-first, CHUNK bits per clock, with optional two's-complement interpretation. It uses a start/done handshake and terminates early on the first differing chunk. It is the sequential, width-generic successor to the team's 4-bit combinational comparator, for datapaths where a wide single-cycle compare would limit timing.

## Interface
- WIDTH, default 16: operand width in bits.
- CHUNK, default 4: bits compared per cycle.
- Legal values: WIDTH % CHUNK == 0, CHUNK ≥ 1, WIDTH ≥ 2.
- CHUNK == WIDTH is legal and gives a single-step compare.

Ports:
- clk  in  1  rising-edge clock; one clock domain only.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- signed_mode  in  1  1 = operands are two's complement; sampled with start.
- a  in  WIDTH  operand A; sampled with start.
- b  in  WIDTH  operand B; sampled with start.
- busy  out  1  high while a compare is in progress.
- done  out  1  single-cycle pulse; result flags are valid in this cycle.
- a_lt_b  out  1  registered result flag.
- a_gt_b  out  1  registered result flag.
- a_eq_b  out  1  registered result flag.

## Operation
- NCH = WIDTH/CHUNK. States are IDLE and RUN.
- **IDLE**
  - On start=1, capture a, b and signed_mode into internal shift registers.
  - Clear the chunk counter; go to RUN.
- **RUN**, each cycle, compare the top CHUNK bits of the A and B shift registers:
  - Signed mode, chunk 0 only: invert the MSB of both chunks before the unsigned compare. This makes a sign difference resolve correctly.
  - Chunks differ: register lt/gt accordingly, eq=0; pulse done; go to IDLE (early termination).
  - Chunks equal, counter == NCH-1: register eq=1, lt=gt=0; pulse done; go to IDLE.
  - Otherwise: shift both registers left by CHUNK; increment the counter.
- After the first completion, exactly one flag is high. Flags hold their value until the next completion.
- Flags are never updated while busy, so they always reflect the last completed compare.
- start while busy is ignored. Input changes while busy have no effect.
- signed_mode has no effect unless the operand sign bits differ.

## Timing
- Reset values: busy=0, done=0, a_lt_b=0, a_gt_b=0, a_eq_b=0; state IDLE; counter 0.
- start sampled high at edge E0 → busy=1 from E0.
- The compare that resolves at chunk k (1..NCH) is registered at edge Ek.
- done=1 and busy=0 in the cycle after Ek.
- Latency is k edges: best case 1, worst case NCH (4 for the defaults).
- start asserted in the done cycle is accepted at the next edge. Back-to-back throughput is one compare per k+1 cycles minimum.
- rst_n low mid-compare: all outputs go to their reset values immediately (asynchronous). No done is issued and the partial result is discarded.
- Deassertion of rst_n is synchronised externally. The first start is honoured at the first edge after release.

## Structure
- Shared package contents:
  - state encoding constants (IDLE, RUN)
  - NCH derivation
  - counter width = clog2(NCH), minimum 1
- Sub-module comparator_chunk: a purely combinational CHUNK-bit unsigned lt/gt/eq. It is instantiated once. The top level handles the signed MSB inversion and the sequencing.
- Parameter legality is checked with an elaboration-time error.

## Test plan
All scenarios use WIDTH=16, CHUNK=4.
- a=0x1234, b=0x1234, unsigned, start → done 4 edges later, a_eq_b=1, lt=gt=0.
- a=0xF000, b=0x8000, unsigned → done after 1 edge, a_gt_b=1.
- a=0xFFFF, b=0x0001, signed → a_lt_b=1 after 1 edge.
- Same operands, unsigned → a_gt_b=1.
- a=0x1235, b=0x1234 → a_gt_b=1 after 4 edges.
- a=0x8000, b=0x8001 signed → a_lt_b=1 after 4 edges.
- Mid-compare handshake:
  - start pulsed with different operands → ignored, result unchanged.
  - New start held in the done cycle → accepted, second result correct.
- rst_n pulsed low at edge 2 of a 4-chunk compare → all outputs 0 at once, no done.
- Afterwards a=3, b=3 → eq=1 after 4 edges.
